// File: rtl/rv32i_top.sv
// Minimal single-cycle RV32I core: PC, word-addressed instruction memory,
// 32x32 register file, decoder and ALU for the OP-IMM / OP instruction classes.

module rv32i_imem #(
  parameter int IMEM_WORDS = 256,
  parameter int AW         = $clog2(IMEM_WORDS)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   instr
);
  // No reset: contents are loaded from outside through the hierarchy.
  logic [31:0] memory [0:IMEM_WORDS-1] = '{default: 32'h0};

  assign instr = memory[addr];
endmodule

module rv32i_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && rd != 5'd0) begin
      registers[rd] <= wdata;
    end
  end

  // Reads see the pre-edge contents; no write-through forwarding.
  assign rdata1 = (rs1 == 5'd0) ? 32'h0 : registers[rs1];
  assign rdata2 = (rs2 == 5'd0) ? 32'h0 : registers[rs2];
endmodule

module rv32i_top #(
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic reset
);
  localparam int AW = $clog2(IMEM_WORDS);

  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } dec_t;

  logic [31:0] pc;
  logic [31:0] instr;
  dec_t        d;
  logic [31:0] rdata1, rdata2;
  logic [31:0] op_a, op_b, alu_res, sra_res;
  logic [4:0]  shamt;
  logic        is_imm, is_op, f7_zero, f7_alt, legal, wr_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pc + 32'd4;
  end

  rv32i_imem #(.IMEM_WORDS(IMEM_WORDS)) instruction_memory (
    .addr  (pc[AW+1:2]),
    .instr (instr)
  );

  always_comb begin
    d.opcode = instr[6:0];
    d.rd     = instr[11:7];
    d.funct3 = instr[14:12];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.funct7 = instr[31:25];
    d.imm    = {{20{instr[31]}}, instr[31:20]};
  end

  rv32i_regfile register_file (
    .clk    (clk),
    .reset  (reset),
    .we     (wr_en),
    .rd     (d.rd),
    .wdata  (alu_res),
    .rs1    (d.rs1),
    .rs2    (d.rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  assign is_imm  = (d.opcode == OPC_IMM);
  assign is_op   = (d.opcode == OPC_OP);
  assign f7_zero = (d.funct7 == F7_ZERO);
  assign f7_alt  = (d.funct7 == F7_ALT);

  // For OP-IMM, imm[4:0] is exactly instr[24:20], i.e. shamt.
  assign op_a    = rdata1;
  assign op_b    = is_op ? rdata2 : d.imm;
  assign shamt   = op_b[4:0];
  assign sra_res = $signed(op_a) >>> shamt;

  always_comb begin
    alu_res = '0;
    legal   = 1'b0;
    unique case (d.funct3)
      3'b000: begin
        legal   = is_imm || f7_zero || f7_alt;
        alu_res = (is_op && f7_alt) ? op_a - op_b : op_a + op_b;
      end
      3'b001: begin
        legal   = f7_zero;
        alu_res = op_a << shamt;
      end
      3'b010: begin
        legal   = is_imm || f7_zero;
        alu_res = {31'h0, $signed(op_a) < $signed(op_b)};
      end
      3'b011: begin
        legal   = is_imm || f7_zero;
        alu_res = {31'h0, op_a < op_b};
      end
      3'b100: begin
        legal   = is_imm || f7_zero;
        alu_res = op_a ^ op_b;
      end
      3'b101: begin
        legal   = f7_zero || f7_alt;
        alu_res = f7_alt ? sra_res : op_a >> shamt;
      end
      3'b110: begin
        legal   = is_imm || f7_zero;
        alu_res = op_a | op_b;
      end
      3'b111: begin
        legal   = is_imm || f7_zero;
        alu_res = op_a & op_b;
      end
      default: begin
        legal   = 1'b0;
        alu_res = '0;
      end
    endcase
  end

  // Unsupported opcodes and reserved funct7 values simply retire without a write.
  assign wr_en = (is_imm || is_op) && legal;

endmodule

// File: tb/tb_rv32i_top.sv
// Self-checking bench for rv32i_top: directed programs plus randomized
// instruction streams compared against an instruction-level reference model.

module tb_rv32i_top;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] ref_mem  [0:255];
  logic [31:0] ref_regs [0:31];
  logic [31:0] ref_pc;

  rv32i_top #(.IMEM_WORDS(256), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPR};
  endfunction

  // Architectural model: one call executes one instruction.
  task automatic ref_step();
    logic [31:0] in, a, b, r;
    logic [4:0]  sh;
    logic [6:0]  f7;
    int          sa, sb;
    bit          ok, is_i;
    in   = ref_mem[ref_pc[9:2]];
    is_i = (in[6:0] == OPI);
    f7   = in[31:25];
    a    = ref_regs[in[19:15]];
    b    = is_i ? {{20{in[31]}}, in[31:20]} : ref_regs[in[24:20]];
    sh   = is_i ? in[24:20] : ref_regs[in[24:20]][4:0];
    sa   = a;
    sb   = b;
    r    = 0;
    ok   = is_i || (in[6:0] == OPR);
    case (in[14:12])
      3'd0: begin
        if (!is_i && f7 == 7'h20) r = a - b; else r = a + b;
        if (!is_i && f7 != 7'h00 && f7 != 7'h20) ok = 0;
      end
      3'd1: begin r = a << sh; if (f7 != 0) ok = 0; end
      3'd2: begin r = (sa < sb) ? 1 : 0; if (!is_i && f7 != 0) ok = 0; end
      3'd3: begin r = (a < b) ? 1 : 0; if (!is_i && f7 != 0) ok = 0; end
      3'd4: begin r = a ^ b; if (!is_i && f7 != 0) ok = 0; end
      3'd5: begin
        if (f7 == 7'h00) r = a >> sh;
        else if (f7 == 7'h20) r = sa >>> sh;
        else ok = 0;
      end
      3'd6: begin r = a | b; if (!is_i && f7 != 0) ok = 0; end
      default: begin r = a & b; if (!is_i && f7 != 0) ok = 0; end
    endcase
    if (ok && in[11:7] != 0) ref_regs[in[11:7]] = r;
    ref_pc = ref_pc + 4;
  endtask

  task automatic put(int idx, logic [31:0] w);
    ref_mem[idx] = w;
    dut.instruction_memory.memory[idx] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) put(i, 32'h0);
  endtask

  task automatic ref_clear();
    ref_pc = 0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    ref_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      ref_step();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    ref_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dut.pc !== 32'h0) begin
      failures++; $display("FAIL reset_pc: got %h expected %h", dut.pc, 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.register_file.registers[i] !== 32'h0) begin
        failures++; $display("FAIL reset_reg x%0d: got %h expected 0", i, dut.register_file.registers[i]);
      end
    end
    checks++;
    if (dut.instruction_memory.memory[0] !== 32'h0) begin
      failures++; $display("FAIL powerup_mem: got %h expected 0", dut.instruction_memory.memory[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    step(3);
    checks++;
    if (dut.pc !== 32'd12) begin
      failures++; $display("FAIL zero_prog_pc: got %h expected %h", dut.pc, 32'd12);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.register_file.registers[i] !== 32'h0) begin
        failures++; $display("FAIL zero_prog_reg x%0d: got %h expected 0", i, dut.register_file.registers[i]);
      end
    end
  endtask

  task automatic test_single_addi();
    clear_mem();
    put(0, 32'h00108113);
    do_reset();
    step(3);
    checks++;
    if (dut.pc !== 32'd12) begin
      failures++; $display("FAIL addi_pc: got %h expected %h", dut.pc, 32'd12);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.register_file.registers[i] !== ((i == 2) ? 32'h1 : 32'h0)) begin
        failures++; $display("FAIL addi_reg x%0d: got %h", i, dut.register_file.registers[i]);
      end
    end
  endtask

  task automatic test_arith();
    logic [31:0] exp_v [1:4];
    clear_mem();
    put(0,  enc_i(-1, 0, 0, 1, OPI));
    put(1,  enc_i(5, 0, 0, 2, OPI));
    put(2,  enc_r(0, 2, 1, 0, 3));
    put(3,  enc_r('h20, 1, 2, 0, 4));
    put(4,  enc_i(0, 1, 2, 5, OPI));
    put(5,  enc_i(-1, 2, 3, 6, OPI));
    put(6,  enc_i('h404, 1, 5, 7, OPI));
    put(7,  enc_i(28, 1, 5, 8, OPI));
    put(8,  enc_i(7, 0, 0, 0, OPI));
    put(9,  enc_r(0, 0, 0, 0, 9));
    put(10, enc_i(3, 2, 7, 11, OPI));
    put(11, enc_i(3, 2, 6, 12, OPI));
    put(12, enc_i(3, 2, 4, 13, OPI));
    put(13, enc_r(0, 2, 2, 1, 10));
    do_reset();
    step(4);
    exp_v[1] = 32'hFFFFFFFF; exp_v[2] = 32'h5; exp_v[3] = 32'h4; exp_v[4] = 32'h6;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (dut.register_file.registers[i] !== exp_v[i]) begin
        failures++; $display("FAIL arith x%0d: got %h expected %h", i, dut.register_file.registers[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_cmp_shift();
    logic [31:0] exp_v [5:8];
    step(4);
    exp_v[5] = 32'h1; exp_v[6] = 32'h1; exp_v[7] = 32'hFFFFFFFF; exp_v[8] = 32'hF;
    for (int i = 5; i <= 8; i++) begin
      checks++;
      if (dut.register_file.registers[i] !== exp_v[i]) begin
        failures++; $display("FAIL cmp_shift x%0d: got %h expected %h", i, dut.register_file.registers[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_x0();
    step(2);
    checks++;
    if (dut.register_file.registers[0] !== 32'h0) begin
      failures++; $display("FAIL x0_write: got %h expected 0", dut.register_file.registers[0]);
    end
    checks++;
    if (dut.register_file.registers[9] !== 32'h0) begin
      failures++; $display("FAIL x0_read x9: got %h expected 0", dut.register_file.registers[9]);
    end
  endtask

  task automatic test_logic();
    logic [31:0] exp_v [10:13];
    step(4);
    exp_v[10] = 32'hA0; exp_v[11] = 32'h1; exp_v[12] = 32'h7; exp_v[13] = 32'h6;
    for (int i = 10; i <= 13; i++) begin
      checks++;
      if (dut.register_file.registers[i] !== exp_v[i]) begin
        failures++; $display("FAIL logic x%0d: got %h expected %h", i, dut.register_file.registers[i], exp_v[i]);
      end
    end
    checks++;
    if (dut.pc !== 32'd56) begin
      failures++; $display("FAIL logic_pc: got %h expected %h", dut.pc, 32'd56);
    end
  endtask

  task automatic test_illegal();
    clear_mem();
    put(0, enc_i(-1, 0, 0, 1, OPI));
    put(1, enc_i(5, 0, 0, 2, OPI));
    put(2, 32'h0);
    put(3, enc_r(1, 2, 1, 0, 3));
    put(4, enc_i('h404, 1, 1, 4, OPI));
    put(5, enc_r('h20, 2, 1, 2, 5));
    put(6, enc_r('h10, 2, 1, 5, 6));
    put(7, 32'h00208463);
    put(8, enc_i('hC04, 1, 5, 7, OPI));
    do_reset();
    step(9);
    checks++;
    if (dut.pc !== 32'd36) begin
      failures++; $display("FAIL illegal_pc: got %h expected %h", dut.pc, 32'd36);
    end
    for (int i = 3; i <= 8; i++) begin
      checks++;
      if (dut.register_file.registers[i] !== 32'h0) begin
        failures++; $display("FAIL illegal_write x%0d: got %h expected 0", i, dut.register_file.registers[i]);
      end
    end
    checks++;
    if (dut.register_file.registers[1] !== 32'hFFFFFFFF || dut.register_file.registers[2] !== 32'h5) begin
      failures++; $display("FAIL illegal_keep: got %h %h expected ffffffff 00000005",
                           dut.register_file.registers[1], dut.register_file.registers[2]);
    end
  endtask

  task automatic test_reset_midrun();
    clear_mem();
    put(0, enc_i(-1, 0, 0, 1, OPI));
    put(1, enc_i(5, 0, 0, 2, OPI));
    put(2, enc_i(9, 0, 0, 3, OPI));
    do_reset();
    step(2);
    checks++;
    if (dut.register_file.registers[2] !== 32'h5) begin
      failures++; $display("FAIL midrun_pre x2: got %h expected 5", dut.register_file.registers[2]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (dut.pc !== 32'h0) begin
      failures++; $display("FAIL midrun_pc: got %h expected 0", dut.pc);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.register_file.registers[i] !== 32'h0) begin
        failures++; $display("FAIL midrun_reg x%0d: got %h expected 0", i, dut.register_file.registers[i]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.register_file.registers[3] !== 32'h0 || dut.pc !== 32'h0) begin
      failures++; $display("FAIL midrun_held: x3=%h pc=%h expected 0 0", dut.register_file.registers[3], dut.pc);
    end
    @(negedge clk);
    reset = 1'b1;
    ref_clear();
    step(1);
    checks++;
    if (dut.register_file.registers[1] !== 32'hFFFFFFFF || dut.register_file.registers[2] !== 32'h0 || dut.pc !== 32'd4) begin
      failures++; $display("FAIL midrun_restart: x1=%h x2=%h pc=%h expected ffffffff 0 4",
                           dut.register_file.registers[1], dut.register_file.registers[2], dut.pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    int sel, k;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 4) w[6:0] = OPI;
      else if (sel < 8) w[6:0] = OPR;
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 31));
      k = $urandom_range(0, 3);
      if (k < 2) w[31:25] = 7'h00;
      else if (k == 2) w[31:25] = 7'h20;
      put(i, w);
    end
    do_reset();
    for (int n = 0; n < 300; n++) begin
      step(1);
      checks++;
      if (dut.pc !== ref_pc) begin
        failures++; $display("FAIL rand_pc step %0d: got %h expected %h", n, dut.pc, ref_pc);
      end
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (dut.register_file.registers[i] !== ref_regs[i]) begin
          failures++; $display("FAIL rand_reg step %0d x%0d: got %h expected %h",
                               n, i, dut.register_file.registers[i], ref_regs[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_addi();
    test_arith();
    test_cmp_shift();
    test_x0();
    test_logic();
    test_illegal();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
